execute_pipe_stage: RTL
=======================

// Module: execute_pipe_stage
// PURPOSE
//  Execute stage of the pipelined Y86-64 core, replacing the combinational SEQ execute block.
//  Takes the decoded E-register bundle and computes valE with the ALU.
//  Holds the architectural condition codes and evaluates cnd for cmovXX/jXX.
//  Drives the E->M pipeline register.
//  Also drives same-cycle forwarding outputs (e_valE, e_dstE) back to decode.
// PARAMETERS
//  DATA_W   64   datapath width; WORD_BYTES = DATA_W/8 is the stack step for call/push/ret/pop
//  RNONE    4'hF register ID meaning "no destination"
// PORTS
//  clock        in   1       rising-edge clock
//  reset_n      in   1       asynchronous active-low reset
//  E_valid      in   1       E-register holds a real instruction (0 = bubble)
//  E_stat       in   3       status from fetch/decode (1 AOK, 2 HLT, 3 ADR, 4 INS)
//  E_icode      in   4       instruction code
//  E_ifun       in   4       function code (ALU op or condition)
//  E_valA       in   DATA_W  operand A from decode
//  E_valB       in   DATA_W  operand B from decode
//  E_valC       in   DATA_W  immediate/displacement
//  E_dstE       in   4       ALU destination register
//  E_dstM       in   4       memory destination register
//  m_exc        in   1       memory stage currently holds a non-AOK stat
//  W_exc        in   1       writeback stage currently holds a non-AOK stat
//  M_stall      in   1       hold the M register
//  M_bubble     in   1       load a nop bubble into the M register
//  e_valE       out  DATA_W  combinational ALU result (forwarding)
//  e_dstE       out  4       combinational effective dstE (forwarding)
//  e_cnd        out  1       combinational condition result
//  cc_zf,cc_sf,cc_of out 1 each  registered condition codes
//  M_valid,M_stat,M_icode,M_cnd,M_valE,M_valA,M_dstE,M_dstM  out  registered E->M bundle
// BEHAVIOUR
//  Reset (async, reset_n=0): cc = {ZF=1,SF=0,OF=0}.
//   M bundle = bubble: valid=0, stat=AOK, icode=NOP(1), cnd=0, valE=valA=0, dstE=dstM=RNONE.
//  aluA: valA for RRMOV/OPq; valC for IRMOV/RMMOV/MRMOV; -WORD_BYTES for CALL/PUSH;
//   +WORD_BYTES for RET/POP; 0 otherwise.
//  aluB: valB for RMMOV/MRMOV/OPq/CALL/PUSH/RET/POP; 0 otherwise.
//  ALU op: ifun when icode=OPq (0 add, 1 sub (B-A), 2 and, 3 xor), else add.
//   Result wraps modulo 2^DATA_W.
//  Flags: ZF=(r==0); SF=r[MSB].
//   add OF = (a[MSB]==b[MSB]) & (r[MSB]!=a[MSB]).
//   sub OF = (a[MSB]!=b[MSB]) & (r[MSB]!=b[MSB]).
//   and/xor OF = 0.
//  set_cc = E_valid & icode==OPq & ~m_exc & ~W_exc & ~M_stall. CC registers load at the edge.
//  cnd is evaluated from the current registered CC, not from this cycle's flags.
//   Conditions: 0 always, 1 le (SF^OF)|ZF, 2 l SF^OF, 3 e ZF, 4 ne ~ZF, 5 ge ~(SF^OF),
//   6 g ~(SF^OF)&~ZF. ifun>6 gives cnd=0.
//  e_dstE = RNONE when icode=RRMOV(cmov) & ~cnd, else E_dstE.
//  E_valid=0 forces e_dstE=RNONE and e_valE=0, and suppresses set_cc.
//  M register, one-cycle latency:
//   M_stall=1: hold all M outputs.
//   else M_bubble=1: load bubble (reset values).
//   else: load the E bundle with cnd/valE/dstE.
//  M_stall & M_bubble both asserted: stall wins; simulation assertion fires.
//  Exception: a non-AOK E_stat passes through unchanged and never sets CC.
//  Reset mid-operation clears CC and M regardless of stall/bubble.
// STRUCTURE
//  y86_pkg: icode/ifun constants, stat codes, RNONE, condition codes, bubble localparams.
//  Sub-module y86_alu #(DATA_W): combinational op -> result, zf/sf/of.
//  Instantiated once here; CC register, cond logic and M register stay in this file.
// TESTING
//  1. Reset low: M_icode=1, M_dstE=F, ZF=1, SF=0, OF=0, including while M_stall=1.
//  2. OPq add with valA=0x7FFF_FFFF_FFFF_FFFF, valB=1 -> valE=0x8000_0000_0000_0000.
//     Next cycle CC = {ZF=0,SF=1,OF=1}.
//  3. OPq sub with valA=5, valB=5 -> valE=0, ZF=1.
//     Repeat with m_exc=1 -> CC unchanged.
//  4. cmovle after CC {ZF=0,SF=0,OF=0}, dstE=3, valA=42 -> e_cnd=0, e_dstE=F.
//     After CC ZF=1 -> e_dstE=3.
//  5. pushq with valB=0x100 -> valE=0xF8. popq -> valE=0x108.
//     Also at DATA_W=32: step is 4.
//  6. Assert M_stall for 2 cycles during an irmovq -> M outputs frozen and CC untouched.
//     Then M_bubble -> M_valid=0, M_icode=1.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the execute stage: instruction and function codes,
// status values, register IDs, M-register bubble contents and condition evaluation.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_op_e;

  typedef enum logic [3:0] {
    C_YES = 4'd0,
    C_LE  = 4'd1,
    C_L   = 4'd2,
    C_E   = 4'd3,
    C_NE  = 4'd4,
    C_GE  = 4'd5,
    C_G   = 4'd6
  } cond_e;

  localparam logic       BUBBLE_VALID = 1'b0;
  localparam logic [2:0] BUBBLE_STAT  = S_AOK;
  localparam logic [3:0] BUBBLE_ICODE = I_NOP;

  // Unlisted condition codes evaluate false so they can never take a branch.
  function automatic logic cond_eval(input logic [3:0] fn, input logic zf,
                                     input logic sf, input logic of);
    logic lt;
    lt = sf ^ of;
    case (fn)
      C_YES:   cond_eval = 1'b1;
      C_LE:    cond_eval = lt | zf;
      C_L:     cond_eval = lt;
      C_E:     cond_eval = zf;
      C_NE:    cond_eval = ~zf;
      C_GE:    cond_eval = ~lt;
      C_G:     cond_eval = ~lt & ~zf;
      default: cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/y86_alu.sv
// Combinational Y86 ALU: add, sub (b - a), and, xor with zero/sign/overflow flags.
module y86_alu
  import y86_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  alu_op_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] r,
  output logic              zf,
  output logic              sf,
  output logic              of
);

  always_comb begin
    r  = '0;
    of = 1'b0;
    case (op)
      ALU_ADD: begin
        r  = b + a;
        of = (a[DATA_W-1] == b[DATA_W-1]) & (r[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        r  = b - a;
        of = (a[DATA_W-1] != b[DATA_W-1]) & (r[DATA_W-1] != b[DATA_W-1]);
      end
      ALU_AND: r = a & b;
      ALU_XOR: r = a ^ b;
      default: r = '0;
    endcase
    zf = (r == '0);
    sf = r[DATA_W-1];
  end

endmodule

// File: rtl/execute_pipe_stage.sv
// Y86-64 pipelined execute stage: ALU operand select, condition codes, cnd evaluation,
// same-cycle forwarding outputs and the E->M pipeline register.
module execute_pipe_stage
  import y86_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              E_valid,
  input  logic [2:0]        E_stat,
  input  logic [3:0]        E_icode,
  input  logic [3:0]        E_ifun,
  input  logic [DATA_W-1:0] E_valA,
  input  logic [DATA_W-1:0] E_valB,
  input  logic [DATA_W-1:0] E_valC,
  input  logic [3:0]        E_dstE,
  input  logic [3:0]        E_dstM,
  input  logic              m_exc,
  input  logic              W_exc,
  input  logic              M_stall,
  input  logic              M_bubble,
  output logic [DATA_W-1:0] e_valE,
  output logic [3:0]        e_dstE,
  output logic              e_cnd,
  output logic              cc_zf,
  output logic              cc_sf,
  output logic              cc_of,
  output logic              M_valid,
  output logic [2:0]        M_stat,
  output logic [3:0]        M_icode,
  output logic              M_cnd,
  output logic [DATA_W-1:0] M_valE,
  output logic [DATA_W-1:0] M_valA,
  output logic [3:0]        M_dstE,
  output logic [3:0]        M_dstM
);

  localparam int                WORD_BYTES = DATA_W / 8;
  localparam logic [DATA_W-1:0] STEP       = DATA_W'(WORD_BYTES);

  logic [DATA_W-1:0] alu_a, alu_b, alu_r;
  alu_op_e           alu_op;
  logic              alu_zf, alu_sf, alu_of;
  logic              set_cc;

  logic              zf_q, sf_q, of_q, zf_d, sf_d, of_d;
  logic              m_valid_q, m_valid_d, m_cnd_q, m_cnd_d;
  logic [2:0]        m_stat_q, m_stat_d;
  logic [3:0]        m_icode_q, m_icode_d, m_dste_q, m_dste_d, m_dstm_q, m_dstm_d;
  logic [DATA_W-1:0] m_vale_q, m_vale_d, m_vala_q, m_vala_d;

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (E_icode)
      I_RRMOVQ, I_OPQ:            alu_a = E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC;
      I_CALL, I_PUSHQ:            alu_a = '0 - STEP;
      I_RET, I_POPQ:              alu_a = STEP;
      default:                    alu_a = '0;
    endcase
    case (E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_PUSHQ, I_RET, I_POPQ: alu_b = E_valB;
      default:                                                   alu_b = '0;
    endcase
    alu_op = ALU_ADD;
    if (E_icode == I_OPQ && E_ifun <= 4'd3) alu_op = alu_op_e'(E_ifun[1:0]);
  end

  y86_alu #(.DATA_W(DATA_W)) u_alu (
    .op (alu_op),
    .a  (alu_a),
    .b  (alu_b),
    .r  (alu_r),
    .zf (alu_zf),
    .sf (alu_sf),
    .of (alu_of)
  );

  // cnd looks at the registered flags: an OPq in this same cycle has not committed yet.
  assign e_cnd = cond_eval(E_ifun, zf_q, sf_q, of_q);

  always_comb begin
    e_valE = alu_r;
    e_dstE = E_dstE;
    if (E_icode == I_RRMOVQ && !e_cnd) e_dstE = RNONE;
    if (!E_valid) begin
      e_valE = '0;
      e_dstE = RNONE;
    end
  end

  assign set_cc = E_valid & (E_icode == I_OPQ) & (E_stat == S_AOK)
                & ~m_exc & ~W_exc & ~M_stall;

  always_comb begin
    zf_d = zf_q;
    sf_d = sf_q;
    of_d = of_q;
    if (set_cc) begin
      zf_d = alu_zf;
      sf_d = alu_sf;
      of_d = alu_of;
    end
  end

  // Stall has priority over bubble so a held instruction is never lost.
  always_comb begin
    m_valid_d = m_valid_q;
    m_stat_d  = m_stat_q;
    m_icode_d = m_icode_q;
    m_cnd_d   = m_cnd_q;
    m_vale_d  = m_vale_q;
    m_vala_d  = m_vala_q;
    m_dste_d  = m_dste_q;
    m_dstm_d  = m_dstm_q;
    if (!M_stall) begin
      if (M_bubble) begin
        m_valid_d = BUBBLE_VALID;
        m_stat_d  = BUBBLE_STAT;
        m_icode_d = BUBBLE_ICODE;
        m_cnd_d   = 1'b0;
        m_vale_d  = '0;
        m_vala_d  = '0;
        m_dste_d  = RNONE;
        m_dstm_d  = RNONE;
      end else begin
        m_valid_d = E_valid;
        m_stat_d  = E_stat;
        m_icode_d = E_icode;
        m_cnd_d   = e_cnd;
        m_vale_d  = e_valE;
        m_vala_d  = E_valA;
        m_dste_d  = e_dstE;
        m_dstm_d  = E_dstM;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      zf_q      <= 1'b1;
      sf_q      <= 1'b0;
      of_q      <= 1'b0;
      m_valid_q <= BUBBLE_VALID;
      m_stat_q  <= BUBBLE_STAT;
      m_icode_q <= BUBBLE_ICODE;
      m_cnd_q   <= 1'b0;
      m_vale_q  <= '0;
      m_vala_q  <= '0;
      m_dste_q  <= RNONE;
      m_dstm_q  <= RNONE;
    end else begin
      zf_q      <= zf_d;
      sf_q      <= sf_d;
      of_q      <= of_d;
      m_valid_q <= m_valid_d;
      m_stat_q  <= m_stat_d;
      m_icode_q <= m_icode_d;
      m_cnd_q   <= m_cnd_d;
      m_vale_q  <= m_vale_d;
      m_vala_q  <= m_vala_d;
      m_dste_q  <= m_dste_d;
      m_dstm_q  <= m_dstm_d;
    end
  end

  assign cc_zf   = zf_q;
  assign cc_sf   = sf_q;
  assign cc_of   = of_q;
  assign M_valid = m_valid_q;
  assign M_stat  = m_stat_q;
  assign M_icode = m_icode_q;
  assign M_cnd   = m_cnd_q;
  assign M_valE  = m_vale_q;
  assign M_valA  = m_vala_q;
  assign M_dstE  = m_dste_q;
  assign M_dstM  = m_dstm_q;

  a_no_stall_and_bubble: assert property (
    @(posedge clock) disable iff (!reset_n) !(M_stall && M_bubble));

endmodule
